// File: rtl/viexo_pkg.sv
// rtl/viexo_pkg.sv - shared AXI burst/response constants and FSM state type for the write slave
package viexo_pkg;

    localparam logic [1:0] VIEXO_BURST_FIXED = 2'b00;
    localparam logic [1:0] VIEXO_BURST_INCR  = 2'b01;
    localparam logic [1:0] VIEXO_BURST_WRAP  = 2'b10;
    localparam logic [1:0] VIEXO_BURST_RSVD  = 2'b11;

    localparam logic [1:0] VIEXO_RESP_OKAY   = 2'b00;
    localparam logic [1:0] VIEXO_RESP_SLVERR = 2'b10;

    localparam logic [2:0] VIEXO_SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } viexo_state_e;

endpackage

// File: rtl/viexo_axi_addr_gen.sv
// rtl/viexo_axi_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module viexo_axi_addr_gen
    import viexo_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [7:0]  len_i,
    input  logic [1:0]  burst_i,
    output logic [31:0] next_addr_o
);

    logic [31:0] incr;
    logic [31:0] wrap_mask;

    always_comb begin
        incr      = addr_i + 32'd4;
        // For legal wrap lengths (1,3,7,15) this is the byte mask of the wrap block.
        wrap_mask = {22'd0, len_i, 2'b11};
        case (burst_i)
            VIEXO_BURST_INCR: next_addr_o = incr;
            VIEXO_BURST_WRAP: next_addr_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
            default:          next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/viexo_axi_wslave.sv
// rtl/viexo_axi_wslave.sv - AXI4 write-only slave producing framebuffer write strobes; VIEXO_AXI_WRAP_EN enables WRAP
module viexo_axi_wslave
    import viexo_pkg::*;
#(
    parameter logic [31:0] FB_BASE = 32'h4000_0000,
    parameter int          FB_AW   = 14
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [31:0]      awaddr,
    input  logic [2:0]       awsize,
    input  logic [7:0]       awlen,
    input  logic [1:0]       awburst,
    input  logic             awvalid,
    output logic             awready,
    input  logic [31:0]      wdata,
    input  logic             wvalid,
    output logic             wready,
    input  logic             wlast,
    output logic [1:0]       bresp,
    output logic             bvalid,
    input  logic             bready,
    output logic             fb_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [31:0]      fb_data
);

    localparam logic [32:0] WIN_BYTES = 33'd4 << FB_AW;

    viexo_state_e     state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [7:0]       len_q, len_d;
    logic [1:0]       burst_q, burst_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             berr_q, berr_d;
    logic             serr_q, serr_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             fb_we_q, fb_we_d;
    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic [31:0]      fb_data_q, fb_data_d;

    logic [31:0]      next_addr;
    logic [31:0]      off;
    logic             in_win;
    logic             last_beat;
    logic             wrap_bad;
    logic             aw_err;

    viexo_axi_addr_gen u_addr_gen (
        .addr_i      (addr_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    assign off       = addr_q - FB_BASE;
    assign in_win    = (addr_q >= FB_BASE) && ({1'b0, off} < WIN_BYTES);
    assign last_beat = (cnt_q == len_q);

    always_comb begin
`ifdef VIEXO_AXI_WRAP_EN
        wrap_bad = !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15});
`else
        wrap_bad = 1'b1;
`endif
        aw_err = (awsize != VIEXO_SIZE_4B) || (awaddr[1:0] != 2'b00) ||
                 (awburst == VIEXO_BURST_RSVD) ||
                 ((awburst == VIEXO_BURST_WRAP) && wrap_bad);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        berr_d    = berr_q;
        serr_d    = serr_q;
        fb_we_d   = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (awvalid && awready_q) begin
                    addr_d  = awaddr;
                    len_d   = awlen;
                    burst_d = awburst;
                    berr_d  = aw_err;
                    serr_d  = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (wvalid && wready_q) begin
                    cnt_d  = cnt_q + 8'd1;
                    addr_d = next_addr;
                    if (in_win && !berr_q) begin
                        fb_we_d   = 1'b1;
                        fb_addr_d = off[FB_AW+1:2];
                        fb_data_d = wdata;
                    end
                    // Out-of-window beats and wlast disagreeing with the count both poison the response.
                    if (!in_win || (wlast != last_beat)) begin
                        serr_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bvalid_q && bready) begin
                    berr_d  = 1'b0;
                    serr_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake outputs are registered copies of the next state.
        awready_d = (state_d == ST_IDLE);
        wready_d  = (state_d == ST_DATA);
        bvalid_d  = (state_d == ST_RESP);
        bresp_d   = ((state_d == ST_RESP) && (berr_d || serr_d)) ? VIEXO_RESP_SLVERR : VIEXO_RESP_OKAY;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            burst_q   <= VIEXO_BURST_FIXED;
            cnt_q     <= 8'd0;
            berr_q    <= 1'b0;
            serr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= VIEXO_RESP_OKAY;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            berr_q    <= berr_d;
            serr_q    <= serr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign fb_we   = fb_we_q;
    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;

endmodule

// File: tb/tb_viexo_axi_wslave.sv
// tb/tb_viexo_axi_wslave.sv - self-checking bench: burst vector table, randomized bursts vs reference model, reset/backpressure corners
module tb_viexo_axi_wslave;

    localparam logic [31:0] FB = 32'h4000_0000;
    localparam int          AW = 14;
`ifdef VIEXO_AXI_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [31:0]   awaddr;
    logic [2:0]    awsize;
    logic [7:0]    awlen;
    logic [1:0]    awburst;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic          wvalid;
    logic          wready;
    logic          wlast;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [31:0]   fb_data;

    viexo_axi_wslave #(.FB_BASE(FB), .FB_AW(AW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awsize(awsize), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;
    typedef struct {
        logic [31:0] a; logic [2:0] sz; logic [7:0] len; logic [1:0] bt;
        int bad; logic [1:0] resp; int nwr;
    } vec_t;

    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [31:0] beat_data [256];
    int          n_chk = 0;
    int          n_pass = 0;

    always @(negedge aclk) begin
        if (aresetn === 1'b1 && fb_we === 1'b1) obs_q.push_back('{fb_addr, fb_data});
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, got running sim, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] model_addr(input logic [31:0] s, input logic [7:0] len,
                                               input logic [1:0] bt, input int i);
        longint unsigned blk, lo;
        case (bt)
            2'b01: return s + 32'(4 * i);
            2'b10: begin
                blk = (longint'(len) + 1) * 4;
                lo  = s - (s % blk);
                return 32'(lo + ((s - lo) + longint'(4 * i)) % blk);
            end
            default: return s;
        endcase
    endfunction

    task automatic model(input logic [31:0] a, input logic [2:0] sz, input logic [7:0] len,
                         input logic [1:0] bt, input int bad, output logic [1:0] resp);
        bit berr, serr;
        logic [31:0] ba;
        longint unsigned off;
        exp_q.delete();
        berr = (sz != 3'b010) || (a[1:0] != 2'b00) || (bt == 2'b11) ||
               (bt == 2'b10 && (!WRAP_EN || !(len inside {8'd1, 8'd3, 8'd7, 8'd15})));
        serr = (bad >= 0) && (bad <= int'(len));
        for (int i = 0; i <= int'(len); i++) begin
            ba  = model_addr(a, len, bt, i);
            off = longint'(ba) - longint'(FB);
            if (ba < FB || off >= longint'(4) * (longint'(1) << AW)) serr = 1'b1;
            else if (!berr) exp_q.push_back('{AW'(off >> 2), beat_data[i]});
        end
        resp = (berr || serr) ? 2'b10 : 2'b00;
    endtask

    task automatic compare_writes(input string tag);
        chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_fb_addr"}, obs_q[i].a, exp_q[i].a);
            chk({tag, "_fb_data"}, obs_q[i].d, exp_q[i].d);
        end
        obs_q.delete();
    endtask

    // Called aligned to posedge+1; returns aligned to posedge+1.
    task automatic do_burst(input logic [31:0] a, input logic [2:0] sz, input logic [7:0] len,
                            input logic [1:0] bt, input int bad, input bit gaps, input int bwait,
                            output logic [1:0] resp);
        int to;
        logic [1:0] r0;
        resp = 2'bxx;
        awaddr = a; awsize = sz; awlen = len; awburst = bt; awvalid = 1'b1;
        to = 0;
        @(negedge aclk);
        while (awready !== 1'b1 && to < 20) begin to++; @(negedge aclk); end
        if (awready !== 1'b1) begin
            chk("aw_timeout", 0, 1); awvalid = 1'b0; @(posedge aclk); #1; return;
        end
        @(posedge aclk); #1 awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 2)) begin @(posedge aclk); #1; end
            wdata = beat_data[i];
            wlast = (i == int'(len)) != (i == bad);
            wvalid = 1'b1;
            to = 0;
            @(negedge aclk);
            while (wready !== 1'b1 && to < 20) begin to++; @(negedge aclk); end
            if (wready !== 1'b1) begin
                chk("w_timeout", 0, 1); wvalid = 1'b0; @(posedge aclk); #1; return;
            end
            @(posedge aclk); #1 wvalid = 1'b0; wlast = 1'b0;
        end
        @(negedge aclk);
        chk("wready_after_last", wready, 0);
        chk("bvalid_after_last", bvalid, 1);
        r0 = bresp;
        for (int k = 0; k < bwait; k++) begin
            @(negedge aclk);
            chk("bvalid_hold", bvalid, 1);
            chk("bresp_stable", bresp, r0);
            chk("awready_during_resp", awready, 0);
        end
        @(posedge aclk); #1 bready = 1'b1;
        to = 0;
        @(negedge aclk);
        while (bvalid !== 1'b1 && to < 20) begin to++; @(negedge aclk); end
        if (bvalid !== 1'b1) chk("b_timeout", 0, 1);
        resp = bresp;
        @(posedge aclk); #1 bready = 1'b0;
        @(negedge aclk);
        chk("bvalid_after_b", bvalid, 0);
        chk("awready_after_b", awready, 1);
        @(posedge aclk); #1;
    endtask

    initial begin
        vec_t        vt[10];
        logic [1:0]  mresp, dresp;
        logic [31:0] a;
        logic [7:0]  len;
        logic [1:0]  bt;
        logic [2:0]  sz;
        int          bad, m;
        int          wl[4];

        wl = '{1, 3, 7, 15};
        vt[0] = '{FB + 32'h10,   3'd2, 8'd3, 2'b01, -1, 2'b00, 4};
        vt[1] = '{FB + 32'h18,   3'd2, 8'd3, 2'b10, -1, WRAP_EN ? 2'b00 : 2'b10, WRAP_EN ? 4 : 0};
        vt[2] = '{FB + 32'h8,    3'd2, 8'd2, 2'b00, -1, 2'b00, 3};
        vt[3] = '{FB + 32'hFFFC, 3'd2, 8'd1, 2'b01, -1, 2'b10, 1};
        vt[4] = '{FB,            3'd1, 8'd1, 2'b01, -1, 2'b10, 0};
        vt[5] = '{FB + 32'h20,   3'd2, 8'd1, 2'b01,  0, 2'b10, 2};
        vt[6] = '{FB + 32'h40,   3'd2, 8'd0, 2'b11, -1, 2'b10, 0};
        vt[7] = '{FB,            3'd2, 8'd2, 2'b10, -1, 2'b10, 0};
        vt[8] = '{FB + 32'h2,    3'd2, 8'd0, 2'b01, -1, 2'b10, 0};
        vt[9] = '{FB - 32'h4,    3'd2, 8'd0, 2'b00, -1, 2'b10, 0};

        aresetn = 1'b0; awaddr = '0; awsize = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wvalid = 1'b1; wlast = 1'b0; bready = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        chk("reset_outputs", {awready, wready, bvalid, fb_we, bresp, fb_addr, fb_data}, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("awready_before_first_edge", awready, 0);
        @(negedge aclk);
        chk("awready_after_first_edge", awready, 1);
        chk("early_wvalid_ignored", wready, 0);
        @(negedge aclk);
        chk("early_wvalid_ignored2", wready, 0);
        chk("no_write_in_idle", obs_q.size(), 0);
        wvalid = 1'b0;
        @(posedge aclk); #1;

        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 256; i++) beat_data[i] = 32'(i + 1);
            model(vt[k].a, vt[k].sz, vt[k].len, vt[k].bt, vt[k].bad, mresp);
            do_burst(vt[k].a, vt[k].sz, vt[k].len, vt[k].bt, vt[k].bad, 1'b0, 0, dresp);
            chk($sformatf("vec%0d_bresp", k), dresp, vt[k].resp);
            chk($sformatf("vec%0d_nwr", k), obs_q.size(), vt[k].nwr);
            compare_writes($sformatf("vec%0d", k));
        end

        // bready held low for 5 cycles while the response waits
        beat_data[0] = 32'hCAFE_0001;
        model(FB + 32'h100, 3'd2, 8'd0, 2'b01, -1, mresp);
        do_burst(FB + 32'h100, 3'd2, 8'd0, 2'b01, -1, 1'b0, 5, dresp);
        chk("bready_hold_bresp", dresp, 2'b00);
        compare_writes("bready_hold");

        // asynchronous reset in the middle of an 8-beat burst
        for (int i = 0; i < 256; i++) beat_data[i] = 32'hA000_0000 + 32'(i);
        awaddr = FB + 32'h200; awsize = 3'd2; awlen = 8'd7; awburst = 2'b01; awvalid = 1'b1;
        @(negedge aclk);
        chk("rst_seq_awready", awready, 1);
        @(posedge aclk); #1 awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = beat_data[i]; wvalid = 1'b1;
            @(posedge aclk); #1;
        end
        #2 aresetn = 1'b0;
        obs_q.delete();
        #1;
        chk("midburst_reset_outputs", {awready, wready, bvalid, fb_we, bresp, fb_addr, fb_data}, 0);
        @(posedge aclk); #1;
        @(posedge aclk); #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("midburst_awready_low", awready, 0);
        @(negedge aclk);
        chk("midburst_awready_back", awready, 1);
        chk("midburst_wready_low", wready, 0);
        repeat (3) @(negedge aclk);
        chk("midburst_no_fb_we", obs_q.size(), 0);
        chk("midburst_no_bvalid", bvalid, 0);
        wvalid = 1'b0;
        @(posedge aclk); #1;

        for (int n = 0; n < 30; n++) begin
            m = int'($urandom_range(0, 9));
            bt = (m < 2) ? 2'b00 : (m < 7) ? 2'b01 : (m < 9) ? 2'b10 : 2'b11;
            if (bt == 2'b10) len = ($urandom_range(0, 7) == 0) ? 8'd2 : 8'(wl[$urandom_range(0, 3)]);
            else len = 8'($urandom_range(0, 7));
            m = int'($urandom_range(0, 9));
            if (m < 6)      a = FB + 32'(4 * $urandom_range(0, (1 << AW) - 1));
            else if (m < 8) a = FB + 32'(4 * ((1 << AW) - int'($urandom_range(1, 4))));
            else if (m < 9) a = FB - 32'(4 * $urandom_range(1, 4));
            else            a = FB + 32'($urandom_range(0, 64));
            sz  = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
            bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(len))) : -1;
            for (int i = 0; i < 256; i++) beat_data[i] = $urandom;
            model(a, sz, len, bt, bad, mresp);
            do_burst(a, sz, len, bt, bad, 1'b1, int'($urandom_range(0, 3)), dresp);
            chk($sformatf("rand%0d_bresp", n), dresp, mresp);
            compare_writes($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
